// File: rtl/matrix_op_arbiter_if.sv
// Requester, engine and status signals of the matrix-op arbiter, bundled for port use.
// slave = arbiter side; master = requesters plus engine side.
interface matrix_op_arbiter_if #(
  parameter int OP_W = 2
);
  logic [1:0]      req;
  logic [OP_W-1:0] op0;
  logic [OP_W-1:0] op1;
  logic [1:0]      ack;
  logic [1:0]      err;
  logic            eng_clr_n;
  logic            eng_start;
  logic [OP_W-1:0] eng_op;
  logic            eng_sel;
  logic            eng_done;
  logic            busy;
  logic [15:0]     done_cnt;
  logic [7:0]      err_cnt;

  modport slave (
    input  req, op0, op1, eng_done,
    output ack, err, eng_clr_n, eng_start, eng_op, eng_sel, busy, done_cnt, err_cnt
  );

  modport master (
    output req, op0, op1, eng_done,
    input  ack, err, eng_clr_n, eng_start, eng_op, eng_sel, busy, done_cnt, err_cnt
  );
endinterface

// File: rtl/matrix_op_arbiter.sv
// Round-robin arbiter for two requesters sharing one matrix engine: clear, start, wait for done or timeout, respond.
// Latency: clear T+1, start T+2, ack one cycle after done/timeout; requests are held until ack, nothing is queued.
module matrix_op_arbiter #(
  parameter int OP_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rst_n,
  matrix_op_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic            grant;
  logic            last_grant;
  logic            pick;
  logic            timed_out;
  logic            rst_done;
  logic            tmo_hit;
  logic [OP_W-1:0] op_q;
  logic [7:0]      tmo_cnt;
  logic [15:0]     done_cnt;
  logic [7:0]      err_cnt;
  logic [1:0]      resp_ack;

  // On contention the requester not served last wins; a lone requester always wins.
  assign pick    = (bus.req == 2'b11) ? ~last_grant : bus.req[1];
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|bus.req) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (bus.eng_done || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      tmo_cnt    <= '0;
      timed_out  <= 1'b0;
      rst_done   <= 1'b0;
      done_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      rst_done <= 1'b1;
      state    <= state_nxt;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            grant <= pick;
            op_q  <= pick ? bus.op1 : bus.op0;
          end
        end
        S_START: begin
          tmo_cnt   <= '0;
          timed_out <= 1'b0;
        end
        S_WAIT: begin
          // Done takes precedence over a timeout landing in the same cycle.
          if (bus.eng_done || tmo_hit) begin
            last_grant <= grant;
            timed_out  <= ~bus.eng_done;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (timed_out) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else begin
            if (done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_ack = (state == S_RESP) ? {grant, ~grant} : 2'b00;

  // Clear is held during reset and released on the first clock out of reset.
  assign bus.eng_clr_n = rst_done & (state != S_CLR);
  assign bus.eng_start = (state == S_START);
  assign bus.eng_op    = op_q;
  assign bus.eng_sel   = grant;
  assign bus.busy      = (state != S_IDLE);
  assign bus.ack       = resp_ack;
  assign bus.err       = timed_out ? resp_ack : 2'b00;
  assign bus.done_cnt  = done_cnt;
  assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_matrix_op_arbiter.sv
// Bench for matrix_op_arbiter: directed vector table, corner sequences, randomized run against a timeline model.
// A second instance with a short timeout exercises error-counter saturation.
module tb_matrix_op_arbiter;
  localparam int OP_W = 2;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  matrix_op_arbiter_if #(.OP_W(OP_W)) bi ();
  matrix_op_arbiter_if #(.OP_W(OP_W)) bi2 ();

  matrix_op_arbiter #(.OP_W(OP_W), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bi));
  matrix_op_arbiter #(.OP_W(OP_W), .TIMEOUT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bi2));

  int checks = 0;
  int errors = 0;
  int n_err2 = 0;

  always @(negedge clk) if (rst2_n === 1'b1 && bi2.err[0] === 1'b1) n_err2++;

  typedef struct {
    logic [1:0] req;
    logic [1:0] op0;
    logic [1:0] op1;
    int         dly;   // done delay in cycles after WAIT entry, -1 = never
    logic       sel;
    logic [1:0] op;
    int         lat;   // ack cycle counted from the IDLE cycle that sampled req
    logic       err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    bi.req = 2'b00;
    bi.eng_done = 1'b0;
    @(negedge clk);
    if (check) begin
      chk("reset ctl", {bi.busy, bi.eng_start, bi.eng_clr_n, bi.eng_sel, bi.eng_op, bi.ack, bi.err}, 0);
      chk("reset cnt", {bi.done_cnt, bi.err_cnt}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (check) chk("reset release", {bi.eng_clr_n, bi.busy}, 2'b10);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ack_n;
    logic [1:0] ack_v, err_v, exp_ack;
    bi.req = v.req;
    bi.op0 = v.op0;
    bi.op1 = v.op1;
    bi.eng_done = 1'b0;
    ack_n = -1;
    ack_v = 2'b00;
    err_v = 2'b00;
    for (int n = 1; n <= 100 && ack_n < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk($sformatf("v%0d clr", idx), {bi.eng_clr_n, bi.eng_start}, 2'b00);
        chk($sformatf("v%0d sel/op", idx), {bi.eng_sel, bi.eng_op}, {v.sel, v.op});
      end
      if (n == 2) chk($sformatf("v%0d start", idx), {bi.eng_clr_n, bi.eng_start}, 2'b11);
      if (bi.ack != 2'b00) begin
        ack_n = n;
        ack_v = bi.ack;
        err_v = bi.err;
      end else if (v.dly >= 0 && n >= 3 + v.dly) begin
        bi.eng_done = 1'b1;
      end
    end
    exp_ack = v.sel ? 2'b10 : 2'b01;
    chk($sformatf("v%0d latency", idx), ack_n, v.lat);
    chk($sformatf("v%0d ack", idx), ack_v, exp_ack);
    chk($sformatf("v%0d err", idx), err_v, v.err ? exp_ack : 2'b00);
    bi.req = 2'b00;
    bi.eng_done = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle", idx), bi.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int exp_done, exp_err, ack_n, stray;
    int act_t[2];
    logic [1:0] act_v[2];
    int nacks;
    // randomized-phase model state
    bit act, w, last, merr;
    int g, len, mdly, mdone, merrc;
    logic [1:0] mop, drv;
    bit [1:0] infl;

    vt[0] = '{req:2'b01, op0:2'd1, op1:2'd0, dly:19, sel:1'b0, op:2'd1, lat:23, err:1'b0};
    vt[1] = '{req:2'b10, op0:2'd0, op1:2'd2, dly:0,  sel:1'b1, op:2'd2, lat:4,  err:1'b0};
    vt[2] = '{req:2'b11, op0:2'd3, op1:2'd1, dly:0,  sel:1'b0, op:2'd3, lat:4,  err:1'b0};
    vt[3] = '{req:2'b11, op0:2'd2, op1:2'd3, dly:5,  sel:1'b1, op:2'd3, lat:9,  err:1'b0};
    vt[4] = '{req:2'b01, op0:2'd2, op1:2'd0, dly:64, sel:1'b0, op:2'd2, lat:68, err:1'b0};
    vt[5] = '{req:2'b10, op0:2'd0, op1:2'd1, dly:-1, sel:1'b1, op:2'd1, lat:68, err:1'b1};
    vt[6] = '{req:2'b11, op0:2'd1, op1:2'd2, dly:63, sel:1'b0, op:2'd1, lat:67, err:1'b0};
    vt[7] = '{req:2'b01, op0:2'd3, op1:2'd0, dly:2,  sel:1'b0, op:2'd3, lat:6,  err:1'b0};

    rst2_n = 1'b0;
    bi2.req = 2'b01;
    bi2.op0 = '0;
    bi2.op1 = '0;
    bi2.eng_done = 1'b0;
    bi.op0 = '0;
    bi.op1 = '0;
    do_reset(1);
    rst2_n = 1'b1;

    exp_done = 0;
    exp_err = 0;
    foreach (vt[i]) begin
      run_vec(vt[i], i);
      if (vt[i].err) exp_err++; else exp_done++;
      chk($sformatf("v%0d counters", i), {bi.done_cnt, bi.err_cnt}, {exp_done[15:0], exp_err[7:0]});
    end

    // Both requesters held, engine done always high: alternating grants every 5 cycles.
    do_reset(0);
    bi.req = 2'b11;
    bi.op0 = 2'd1;
    bi.op1 = 2'd2;
    bi.eng_done = 1'b1;
    stray = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n % 5 == 1) chk($sformatf("rr sel n%0d", n), bi.eng_sel, (n / 5) % 2);
      if (n % 5 == 4) chk($sformatf("rr ack n%0d", n), bi.ack, ((n / 5) % 2) ? 2'b10 : 2'b01);
      else if (bi.ack != 2'b00) stray++;
      if (n == 19) bi.req = 2'b00;
    end
    chk("rr stray ack", stray, 0);
    chk("rr done_cnt", bi.done_cnt, 4);

    // Stale done through IDLE/CLR/START must not complete the request.
    bi.req = 2'b01;
    bi.op0 = 2'd2;
    bi.eng_done = 1'b1;
    ack_n = -1;
    for (int n = 1; n <= 30 && ack_n < 0; n++) begin
      @(negedge clk);
      if (bi.ack != 2'b00) ack_n = n;
      else if (n == 3) bi.eng_done = 1'b0;
      else if (n == 8) bi.eng_done = 1'b1;
    end
    chk("stale done ack time", ack_n, 9);
    bi.req = 2'b00;
    bi.eng_done = 1'b0;
    @(negedge clk);
    chk("stale done_cnt", bi.done_cnt, 5);

    // Reset pulse in WAIT abandons requester 1; afterwards requester 0 wins contention.
    bi.req = 2'b10;
    bi.op1 = 2'd3;
    repeat (5) @(negedge clk);
    chk("midreset in wait", {bi.busy, bi.eng_sel}, 2'b11);
    bi.req = 2'b11;
    bi.op0 = 2'd1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset ctl", {bi.busy, bi.eng_start, bi.eng_clr_n, bi.eng_sel, bi.eng_op, bi.ack, bi.err}, 0);
    chk("midreset cnt", {bi.done_cnt, bi.err_cnt}, 0);
    rst_n = 1'b1;
    nacks = 0;
    act_t[0] = -1; act_t[1] = -1;
    act_v[0] = 2'b00; act_v[1] = 2'b00;
    for (int n = 1; n <= 40 && nacks < 2; n++) begin
      @(negedge clk);
      if (n == 1) chk("midreset regrant", {bi.eng_clr_n, bi.eng_sel, bi.eng_op}, {1'b0, 1'b0, 2'd1});
      bi.eng_done = 1'b1;
      if (bi.ack != 2'b00) begin
        act_t[nacks] = n;
        act_v[nacks] = bi.ack;
        nacks++;
        bi.req = bi.req & ~bi.ack;
      end
    end
    chk("midreset first ack", {act_t[0][7:0], act_v[0]}, {8'd4, 2'b01});
    chk("midreset second ack", {act_t[1][7:0], act_v[1]}, {8'd9, 2'b10});
    bi.req = 2'b00;
    bi.eng_done = 1'b0;
    @(negedge clk);
    chk("midreset done_cnt", bi.done_cnt, 2);

    // Randomized traffic checked against a timeline model measured from each grant cycle.
    do_reset(0);
    act = 1'b0; w = 1'b0; last = 1'b1; merr = 1'b0;
    g = 0; len = 0; mdly = 0; mdone = 0; merrc = 0;
    mop = '0; drv = 2'b00; infl = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      int r;
      bit inwin;
      logic [1:0] eack;
      r = act ? c - g : -1;
      inwin = act && r >= 1 && r <= 4 + len;
      eack = (inwin && r == 4 + len) ? (w ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rnd ctl c%0d", c), {bi.busy, bi.eng_clr_n, bi.eng_start, bi.ack, bi.err},
          {inwin, !(inwin && r == 1), inwin && r == 2, eack, merr ? eack : 2'b00});
      if (inwin) chk($sformatf("rnd sel/op c%0d", c), {bi.eng_sel, bi.eng_op}, {w, mop});
      chk($sformatf("rnd cnt c%0d", c), {bi.done_cnt, bi.err_cnt}, {mdone[15:0], merrc[7:0]});
      if (eack != 2'b00) begin
        if (merr) merrc = (merrc < 255) ? merrc + 1 : merrc;
        else mdone = (mdone < 65535) ? mdone + 1 : mdone;
        infl[w] = 1'b0;
        drv[w] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!drv[i] && !infl[i] && $urandom_range(3) == 0) begin
          drv[i] = 1'b1;
          if (i == 0) bi.op0 = 2'($urandom); else bi.op1 = 2'($urandom);
        end else if (drv[i] && infl[i] && $urandom_range(7) == 0) begin
          drv[i] = 1'b0;
        end
      end
      bi.req = drv;
      if (!inwin && drv != 2'b00) begin
        w = (drv == 2'b11) ? !last : drv[1];
        last = w;
        g = c;
        act = 1'b1;
        mop = w ? bi.op1 : bi.op0;
        infl[w] = 1'b1;
        case ($urandom_range(7))
          0, 1, 2, 3: mdly = $urandom_range(7);
          4:          mdly = $urandom_range(40, 8);
          5:          mdly = TMO;
          6:          mdly = TMO - 1;
          default:    mdly = -1;
        endcase
        len = (mdly < 0) ? TMO : mdly;
        merr = (mdly < 0);
      end
      r = act ? c - g : -1;
      if (act && r >= 3 && r <= 3 + len) bi.eng_done = (mdly >= 0 && r >= 3 + mdly);
      else bi.eng_done = 1'($urandom_range(1));
      @(negedge clk);
    end

    chk("sat err_cnt", bi2.err_cnt, 8'hFF);
    chk("sat done_cnt", bi2.done_cnt, 0);
    chk("sat timeouts seen", n_err2 > 255, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
